ex_fsm_ser: RTL and testbench

Parallel-to-serial front end for the sequence-detector FSM. It accepts words of programmable length over a valid/ready handshake and shifts them out MSB-first as a one-bit-per-clock stream. The stream drives the detector's `cin` input directly. A one-entry holding register lets consecutive words go out without bubbles, so the detector sees continuous patterns across word boundaries.

---
 rtl/ex_fsm_ser.sv | 125 ++++++++++++
 tb/tb_ex_fsm_ser.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ex_fsm_ser.sv
`default_nettype none
// ============================================================================
// Module   : ex_fsm_ser
// Purpose  : Parallel-to-serial front end for the sequence detector. Accepts
//            words of programmable length over a valid/ready handshake and
//            shifts them out MSB-first, one bit per clock. A one-entry holding
//            register lets consecutive words leave without bubbles.
// Ports    : sclk      - clock, rising edge
//            rst       - asynchronous active-high reset
//            din       - parallel word, bits [len-1:0] are sent
//            din_len   - bits to send (1..DW); 0 or >DW means DW
//            din_vld   - upstream offers din/din_len
//            din_rdy   - holding register empty
//            cout      - registered serial bit (to detector cin)
//            cout_vld  - cout carries a data bit
//            busy      - shifter or holding register occupied
// Revision : 1.0 - initial release
// ============================================================================
module ex_fsm_ser #(
    parameter int   DW       = 8,
    parameter int   LW       = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic          sclk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic [LW-1:0] din_len,
    input  logic          din_vld,
    output logic          din_rdy,
    output logic          cout,
    output logic          cout_vld,
    output logic          busy
);

    localparam logic [0:0]    c_IDLE    = 1'b0;
    localparam logic [0:0]    c_SHIFT   = 1'b1;
    localparam logic [LW-1:0] c_LEN_MAX = LW'(DW);
    localparam logic [LW-1:0] c_ONE     = LW'(1);

    logic [0:0]    r_state;
    logic          r_hold_full;
    logic [DW-1:0] r_hold_dat;
    logic [LW-1:0] r_hold_len;
    logic [DW-1:0] r_sh_dat;
    logic [LW-1:0] r_bit_cnt;
    logic          r_cout;
    logic          r_cout_vld;

    logic          w_accept;
    logic          w_last;
    logic          w_load;
    logic [LW-1:0] w_len_norm;
    logic [DW-1:0] w_load_dat;
    logic [0:0]    w_state_nxt;
    logic [DW-1:0] w_sh_nxt;
    logic [LW-1:0] w_cnt_nxt;

    assign din_rdy  = ~r_hold_full;
    assign w_accept = din_vld & ~r_hold_full;
    assign busy     = r_hold_full | (r_state == c_SHIFT);
    assign cout     = r_cout;
    assign cout_vld = r_cout_vld;

    // Out-of-range lengths collapse to a full word.
    assign w_len_norm = ((din_len == '0) || (din_len > c_LEN_MAX)) ? c_LEN_MAX : din_len;

    // Left-align the held word so its first bit sits at the shifter MSB;
    // unused upper bits of din fall off the top.
    assign w_load_dat = r_hold_dat << (c_LEN_MAX - r_hold_len);

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh_dat;
        w_cnt_nxt   = r_bit_cnt;
        w_last      = (r_state == c_SHIFT) && (r_bit_cnt == c_ONE);
        w_load      = r_hold_full && ((r_state == c_IDLE) || w_last);
        if (w_load) begin
            // Reloading on the last-bit edge keeps the stream gapless.
            w_state_nxt = c_SHIFT;
            w_sh_nxt    = w_load_dat;
            w_cnt_nxt   = r_hold_len;
        end else if (w_last) begin
            w_state_nxt = c_IDLE;
            w_sh_nxt    = '0;
            w_cnt_nxt   = '0;
        end else if (r_state == c_SHIFT) begin
            w_sh_nxt    = {r_sh_dat[DW-2:0], 1'b0};
            w_cnt_nxt   = r_bit_cnt - c_ONE;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_sh_dat   <= '0;
            r_bit_cnt  <= '0;
            r_cout     <= IDLE_BIT;
            r_cout_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sh_dat   <= w_sh_nxt;
            r_bit_cnt  <= w_cnt_nxt;
            // Output flops take the bit the shifter will present next cycle.
            r_cout     <= (w_state_nxt == c_SHIFT) ? w_sh_nxt[DW-1] : IDLE_BIT;
            r_cout_vld <= (w_state_nxt == c_SHIFT);
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold_dat  <= '0;
            r_hold_len  <= '0;
        end else if (w_accept) begin
            // A new word wins over a simultaneous load.
            r_hold_full <= 1'b1;
            r_hold_dat  <= din;
            r_hold_len  <= w_len_norm;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_fsm_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_fsm_ser
// Purpose  : Self-checking bench for ex_fsm_ser: reset state, single words
//            from a vector table, back-to-back, length-1 stream, mid-word reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_fsm_ser;

    logic       sclk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [3:0] din_len;
    logic       din_vld;
    logic       din_rdy;
    logic       cout;
    logic       cout_vld;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    ex_fsm_ser #(.DW(8), .LW(4), .IDLE_BIT(1'b0)) dut (
        .sclk     (sclk),
        .rst      (rst),
        .din      (din),
        .din_len  (din_len),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .cout     (cout),
        .cout_vld (cout_vld),
        .busy     (busy)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        string      name;
        logic [7:0] din;
        logic [3:0] len;
        int         n;
        logic [15:0] bits;   // bits[n-1] goes out first
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_word(input vec_t v);
        @(negedge sclk);
        din     = v.din;
        din_len = v.len;
        din_vld = 1'b1;
        @(posedge sclk);
        @(negedge sclk);
        din_vld = 1'b0;
        din     = 8'h00;
        din_len = 4'd1;
        chk({v.name, "_pre_vld"}, 32'(cout_vld), 32'd0);
        for (int i = 0; i < v.n; i++) begin
            @(negedge sclk);
            chk($sformatf("%s_vld%0d", v.name, i), 32'(cout_vld), 32'd1);
            chk($sformatf("%s_bit%0d", v.name, i), 32'(cout), 32'(v.bits[v.n-1-i]));
        end
        @(negedge sclk);
        chk({v.name, "_end_vld"}, 32'(cout_vld), 32'd0);
        chk({v.name, "_end_busy"}, 32'(busy), 32'd0);
    endtask

    // Offers nw words back-to-back, advancing on each handshake; per-cycle
    // expectations are strings indexed by cycle ('-' = don't care for cout).
    task automatic run_stream(input string name, input int nw,
                              input logic [3:0][7:0] d, input logic [3:0][3:0] l,
                              input string ev, input string ec, input string er);
        int   nacc;
        logic acc;
        nacc = 0;
        @(negedge sclk);
        din     = d[0];
        din_len = l[0];
        din_vld = 1'b1;
        for (int c = 0; c < ev.len(); c++) begin
            acc = din_vld && din_rdy;
            @(negedge sclk);
            if (acc) begin
                nacc++;
                if (nacc >= nw) din_vld = 1'b0;
                else begin
                    din     = d[nacc];
                    din_len = l[nacc];
                end
            end
            chk($sformatf("%s_vld%0d", name, c), 32'(cout_vld), 32'(ev[c] == "1"));
            if (ec[c] != "-")
                chk($sformatf("%s_bit%0d", name, c), 32'(cout), 32'(ec[c] == "1"));
            chk($sformatf("%s_rdy%0d", name, c), 32'(din_rdy), 32'(er[c] == "1"));
        end
        din_vld = 1'b0;
        chk({name, "_nacc"}, 32'(nacc), 32'(nw));
    endtask

    initial begin
        logic quiet;
        tbl[0] = '{"w5_01001", 8'b0000_1001, 4'd5,  5, 16'b01001};
        tbl[1] = '{"len0_a5",  8'hA5,        4'd0,  8, 16'b10100101};
        tbl[2] = '{"len15_a5", 8'hA5,        4'd15, 8, 16'b10100101};
        tbl[3] = '{"len9_a5",  8'hA5,        4'd9,  8, 16'b10100101};
        tbl[4] = '{"len3_f2",  8'b1111_0010, 4'd3,  3, 16'b010};
        tbl[5] = '{"len8_80",  8'h80,        4'd8,  8, 16'b10000000};
        tbl[6] = '{"len1_01",  8'h01,        4'd1,  1, 16'b1};
        tbl[7] = '{"len6_3c",  8'h3C,        4'd6,  6, 16'b111100};

        rst     = 1'b1;
        din     = 8'h00;
        din_len = 4'd0;
        din_vld = 1'b0;
        #50;
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_vld",  32'(cout_vld), 32'd0);
        chk("rst_rdy",  32'(din_rdy), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        #50;
        rst = 1'b0;
        repeat (5) @(negedge sclk);
        chk("idle_cout", 32'(cout), 32'd0);
        chk("idle_vld",  32'(cout_vld), 32'd0);
        chk("idle_rdy",  32'(din_rdy), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) run_word(tbl[i]);

        // 01001 then 10101, held valid: ten gapless bits.
        run_stream("b2b", 2, {8'h00, 8'h00, 8'b0001_0101, 8'b0000_1001},
                   {4'd0, 4'd0, 4'd5, 4'd5},
                   "011111111110", "-0100110101-", "010000111111");
        chk("b2b_busy", 32'(busy), 32'd0);

        // Length-1 words 1,0,1,1: cout_vld toggles.
        run_stream("len1", 4, {8'h01, 8'h01, 8'h00, 8'h01},
                   {4'd1, 4'd1, 4'd1, 4'd1},
                   "010101010", "-1-0-1-1-", "010101011");

        // Reset after three bits of A5 with a second word waiting.
        run_stream("midrst", 2, {8'h00, 8'h00, 8'h3C, 8'hA5},
                   {4'd0, 4'd0, 4'd8, 4'd8},
                   "0111", "-101", "0100");
        #2 rst = 1'b1;
        #1;
        chk("midrst_vld",  32'(cout_vld), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rdy",  32'(din_rdy), 32'd1);
        chk("midrst_cout", 32'(cout), 32'd0);
        repeat (2) @(negedge sclk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge sclk);
            if (cout_vld !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("midrst_quiet", 32'(quiet), 32'd1);
        run_word(tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
